dzcpu_uop_sequencer: RTL and testbench

Micro-program sequencer for the dzcpu core; it consumes the micro-op stream produced by the microcode flow-index LUTs and micro-op ROM. It latches each fetched opcode, dispatches to its flow start address (regular or 0xCB table), steps the micro-program counter, and decodes the per-uop flow-control field into PC-increment, flag-update and end-of-flow actions for the datapath. It sits between the memory data bus / LUTs / ROM and the dzcpu execution datapath.

---
 rtl/dzcpu_uop_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_dzcpu_uop_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu_uop_sequencer: micro-program sequencer for the dzcpu core.
// Latches each fetched opcode, jumps to its flow start address (regular or
// CB table), walks the micro-program counter through the uop ROM, and
// decodes each uop's flow-control field into PC-increment, flag-update and
// end-of-flow strobes for the datapath.
// Optional build macro: DZCPU_USEQ_WDOG_EN adds a per-flow uop watchdog that
// forces end-of-flow after P_WDOG_MAX uops and raises a sticky oUopError.
module dzcpu_uop_sequencer #(
  parameter logic [4:0] P_JCB      = 5'd20,
  parameter logic [7:0] P_WDOG_MAX = 8'd255
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMop,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  input  logic [12:0] iUop,
  input  logic        iFlagZ,
  input  logic        iStall,
  output logic [7:0]  oUpc,
  output logic [7:0]  oOpcode,
  output logic        oCbMode,
  output logic        oUopValid,
  output logic [4:0]  oOp,
  output logic [3:0]  oOperand,
  output logic        oPcInc,
  output logic        oFlagUpdate,
  output logic        oEof,
  output logic        oUopError
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_DISPATCH,
    ST_EXEC,
    ST_CB_DISPATCH
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] upc_reg, upc_next;
  logic [7:0] opcode_reg, opcode_next;
  logic       cb_mode_reg, cb_mode_next;
  logic       uop_error_reg, uop_error_next;

  logic [3:0] flow_code;
  logic [4:0] uop_op;
  logic       pc_inc;
  logic       flag_upd;
  logic       flow_end;

`ifdef DZCPU_USEQ_WDOG_EN
  logic [7:0] wdog_cnt_reg, wdog_cnt_next;
`endif

  assign flow_code = iUop[12:9];
  assign uop_op    = iUop[8:4];

  assign oUpc      = upc_reg;
  assign oOpcode   = opcode_reg;
  assign oCbMode   = cb_mode_reg;
  assign oUopError = uop_error_reg;

  // Next-state, register updates and per-uop datapath strobes.
  always_comb begin
    state_next     = state_reg;
    upc_next       = upc_reg;
    opcode_next    = opcode_reg;
    cb_mode_next   = cb_mode_reg;
    uop_error_next = uop_error_reg;
`ifdef DZCPU_USEQ_WDOG_EN
    wdog_cnt_next  = wdog_cnt_reg;
`endif
    pc_inc      = 1'b0;
    flag_upd    = 1'b0;
    flow_end    = 1'b0;
    oUopValid   = 1'b0;
    oOp         = 5'd0;
    oOperand    = 4'd0;
    oPcInc      = 1'b0;
    oFlagUpdate = 1'b0;
    oEof        = 1'b0;

    case (state_reg)
      ST_RST: begin
        state_next = ST_DISPATCH;
      end

      ST_DISPATCH: begin
        opcode_next = iMop;
        upc_next    = iFlowIdx;
        state_next  = ST_EXEC;
`ifdef DZCPU_USEQ_WDOG_EN
        wdog_cnt_next = 8'd0;
`endif
      end

      ST_CB_DISPATCH: begin
        opcode_next  = iMop;
        upc_next     = iCbFlowIdx;
        cb_mode_next = 1'b1;
        state_next   = ST_EXEC;
`ifdef DZCPU_USEQ_WDOG_EN
        wdog_cnt_next = 8'd0;
`endif
      end

      ST_EXEC: begin
        oOp      = uop_op;
        oOperand = iUop[3:0];

        // Codes 0 and 8..15 simply continue to the next uop.
        case (flow_code)
          4'd1: pc_inc = 1'b1;
          4'd2: flow_end = 1'b1;
          4'd3: begin
            pc_inc   = 1'b1;
            flow_end = 1'b1;
          end
          4'd4: begin
            flag_upd = 1'b1;
            flow_end = 1'b1;
          end
          4'd5: begin
            pc_inc   = 1'b1;
            flag_upd = 1'b1;
            flow_end = 1'b1;
          end
          4'd6: begin
            pc_inc   = 1'b1;
            flow_end = iFlagZ;
          end
          4'd7: begin
            pc_inc   = 1'b1;
            flow_end = ~iFlagZ;
          end
          default: ;
        endcase

`ifdef DZCPU_USEQ_WDOG_EN
        // This uop is the P_WDOG_MAX-th of the flow: cut the flow short.
        wdog_cnt_next = wdog_cnt_reg + 8'd1;
        if (wdog_cnt_reg == P_WDOG_MAX - 8'd1) begin
          flow_end       = 1'b1;
          uop_error_next = 1'b1;
        end
`endif

        // An ending flow code beats a jump to the CB table.
        if (flow_end) begin
          cb_mode_next = 1'b0;
          state_next   = ST_DISPATCH;
        end else if (uop_op == P_JCB) begin
          state_next = ST_CB_DISPATCH;
        end else begin
          upc_next = upc_reg + 8'd1;
        end

        oUopValid   = 1'b1;
        oPcInc      = pc_inc;
        oFlagUpdate = flag_upd;
        oEof        = flow_end;
      end

      default: state_next = ST_RST;
    endcase

    // A memory wait freezes every register and suppresses all strobes.
    if (iStall) begin
      state_next     = state_reg;
      upc_next       = upc_reg;
      opcode_next    = opcode_reg;
      cb_mode_next   = cb_mode_reg;
      uop_error_next = uop_error_reg;
`ifdef DZCPU_USEQ_WDOG_EN
      wdog_cnt_next  = wdog_cnt_reg;
`endif
      oUopValid   = 1'b0;
      oPcInc      = 1'b0;
      oFlagUpdate = 1'b0;
      oEof        = 1'b0;
    end
  end

  // State register; reset discards any in-flight flow immediately.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_reg     <= ST_RST;
      upc_reg       <= 8'd0;
      opcode_reg    <= 8'd0;
      cb_mode_reg   <= 1'b0;
      uop_error_reg <= 1'b0;
`ifdef DZCPU_USEQ_WDOG_EN
      wdog_cnt_reg  <= 8'd0;
`endif
    end else begin
      state_reg     <= state_next;
      upc_reg       <= upc_next;
      opcode_reg    <= opcode_next;
      cb_mode_reg   <= cb_mode_next;
      uop_error_reg <= uop_error_next;
`ifdef DZCPU_USEQ_WDOG_EN
      wdog_cnt_reg  <= wdog_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Self-checking bench for dzcpu_uop_sequencer (default build, watchdog off).
// A behavioural ROM answers oUpc combinationally; each scenario queues its
// per-cycle stimulus and the expected outputs, then drives and compares.
module tb_dzcpu_uop_sequencer;

  logic        iClock;
  logic        iReset;
  logic [7:0]  iMop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [12:0] iUop;
  logic        iFlagZ;
  logic        iStall;
  logic [7:0]  oUpc;
  logic [7:0]  oOpcode;
  logic        oCbMode;
  logic        oUopValid;
  logic [4:0]  oOp;
  logic [3:0]  oOperand;
  logic        oPcInc;
  logic        oFlagUpdate;
  logic        oEof;
  logic        oUopError;

  dzcpu_uop_sequencer dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iMop        (iMop),
    .iFlowIdx    (iFlowIdx),
    .iCbFlowIdx  (iCbFlowIdx),
    .iUop        (iUop),
    .iFlagZ      (iFlagZ),
    .iStall      (iStall),
    .oUpc        (oUpc),
    .oOpcode     (oOpcode),
    .oCbMode     (oCbMode),
    .oUopValid   (oUopValid),
    .oOp         (oOp),
    .oOperand    (oOperand),
    .oPcInc      (oPcInc),
    .oFlagUpdate (oFlagUpdate),
    .oEof        (oEof),
    .oUopError   (oUopError)
  );

  typedef struct packed {
    logic [7:0] upc;
    logic [7:0] opcode;
    logic       cb;
    logic       valid;
    logic [4:0] op;
    logic [3:0] operand;
    logic       pcinc;
    logic       fu;
    logic       eof;
    logic       err;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    obs_t mask;
  } sb_t;

  typedef struct packed {
    logic       rst_n;
    logic       stall;
    logic       z;
    logic [7:0] mop;
    logic [7:0] flow;
    logic [7:0] cbflow;
  } stim_t;

  localparam logic [4:0] JCB = 5'd20;

  logic [12:0] rom [256];
  obs_t        obs;
  sb_t         sb_q [$];
  stim_t       stim_q [$];
  int          tests_run;
  int          tests_failed;
  logic [7:0]  last_opc;

  assign iUop = rom[oUpc];
  assign obs  = {oUpc, oOpcode, oCbMode, oUopValid, oOp, oOperand,
                 oPcInc, oFlagUpdate, oEof, oUopError};

  initial begin
    iClock = 1'b0;
    forever #5 iClock = ~iClock;
  end

  function automatic logic [12:0] uop(input logic [3:0] code, input logic [4:0] op,
                                      input logic [3:0] operand);
    return {code, op, operand};
  endfunction

  function automatic stim_t st(input logic rst_n, input logic stall, input logic z,
                               input logic [7:0] mop, input logic [7:0] flow,
                               input logic [7:0] cbflow);
    stim_t s;
    s.rst_n = rst_n; s.stall = stall; s.z = z;
    s.mop = mop; s.flow = flow; s.cbflow = cbflow;
    return s;
  endfunction

  // Normal running cycle stimulus.
  function automatic stim_t sn(input logic z, input logic [7:0] mop, input logic [7:0] flow,
                               input logic [7:0] cbflow);
    return st(1'b1, 1'b0, z, mop, flow, cbflow);
  endfunction

  // Expected issuing cycle: every field checked.
  function automatic sb_t e_exec(input logic [7:0] upc, input logic [7:0] opc, input logic cb,
                                 input logic [4:0] op, input logic [3:0] operand,
                                 input logic pi, input logic fu, input logic eof);
    sb_t e;
    e.exp  = {upc, opc, cb, 1'b1, op, operand, pi, fu, eof, 1'b0};
    e.mask = '1;
    return e;
  endfunction

  // Expected non-issuing cycle; op/operand are don't-care, upc optionally.
  function automatic sb_t e_idle(input logic [7:0] upc, input logic [7:0] opc, input logic cb,
                                 input logic upc_care);
    sb_t e;
    e.exp  = {upc, opc, cb, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    e.mask = '1;
    e.mask.op      = 5'd0;
    e.mask.operand = 4'd0;
    if (!upc_care) e.mask.upc = 8'd0;
    return e;
  endfunction

  // Expected reset / RST-state cycle: everything zero.
  function automatic sb_t e_zero();
    sb_t e;
    e.exp  = '0;
    e.mask = '1;
    return e;
  endfunction

  task automatic add(input stim_t s, input sb_t e);
    stim_q.push_back(s);
    sb_q.push_back(e);
  endtask

  task automatic run_cycle(input stim_t s);
    @(posedge iClock);
    #1;
    iReset     = s.rst_n;
    iStall     = s.stall;
    iFlagZ     = s.z;
    iMop       = s.mop;
    iFlowIdx   = s.flow;
    iCbFlowIdx = s.cbflow;
    @(negedge iClock);
  endtask

  task automatic test_reset();
    sb_t e;
    int  n = 0;
    rom[0] = uop(4'd3, 5'd3, 4'hA);
    add(st(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hEE), e_zero());
    add(st(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hEE), e_zero());
    add(sn(1'b0, 8'h00, 8'h00, 8'hEE), e_zero());
    add(sn(1'b0, 8'h00, 8'h00, 8'hEE), e_idle(8'd0, 8'h00, 1'b0, 1'b1));
    add(sn(1'b0, 8'hFF, 8'hFF, 8'hEE), e_exec(8'd0, 8'h00, 1'b0, 5'd3, 4'hA, 1'b1, 1'b0, 1'b1));
    last_opc = 8'h00;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL reset cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] reset cycle %0d ok upc=%0d valid=%0b pcinc=%0b eof=%0b", n, oUpc, oUopValid, oPcInc, oEof);
      n++;
    end
  endtask

  task automatic test_flow_sequence();
    sb_t e;
    int  n = 0;
    rom[1] = uop(4'd1, 5'd1, 4'd1);
    rom[2] = uop(4'd1, 5'd2, 4'd2);
    rom[3] = uop(4'd0, 5'd3, 4'd3);
    rom[4] = uop(4'd3, 5'd4, 4'd4);
    add(sn(1'b0, 8'h3E, 8'd1, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd1, 8'h3E, 1'b0, 5'd1, 4'd1, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd2, 8'h3E, 1'b0, 5'd2, 4'd2, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd3, 8'h3E, 1'b0, 5'd3, 4'd3, 1'b0, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd4, 8'h3E, 1'b0, 5'd4, 4'd4, 1'b1, 1'b0, 1'b1));
    last_opc = 8'h3E;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL flow_seq cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] flow_seq cycle %0d ok upc=%0d pcinc=%0b eof=%0b", n, oUpc, oPcInc, oEof);
      n++;
    end
  endtask

  task automatic test_conditional();
    sb_t e;
    int  n = 0;
    rom[10] = uop(4'd6, 5'd6, 4'd0);
    rom[11] = uop(4'd6, 5'd7, 4'd1);
    rom[12] = uop(4'd2, 5'd8, 4'd2);
    rom[20] = uop(4'd7, 5'd9, 4'd3);
    rom[21] = uop(4'd2, 5'd10, 4'd4);
    // code 6, Z=1: ends at once
    add(sn(1'b0, 8'h20, 8'd10, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b1, 8'h00, 8'd0, 8'hEE), e_exec(8'd10, 8'h20, 1'b0, 5'd6, 4'd0, 1'b1, 1'b0, 1'b1));
    // code 6, Z=0: continues twice, then plain eof
    add(sn(1'b0, 8'h21, 8'd10, 8'hEE), e_idle(8'd0, 8'h20, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd10, 8'h21, 1'b0, 5'd6, 4'd0, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd11, 8'h21, 1'b0, 5'd7, 4'd1, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd12, 8'h21, 1'b0, 5'd8, 4'd2, 1'b0, 1'b0, 1'b1));
    // code 7, Z=0: ends at once
    add(sn(1'b1, 8'h22, 8'd20, 8'hEE), e_idle(8'd0, 8'h21, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd20, 8'h22, 1'b0, 5'd9, 4'd3, 1'b1, 1'b0, 1'b1));
    // code 7, Z=1: continues
    add(sn(1'b0, 8'h23, 8'd20, 8'hEE), e_idle(8'd0, 8'h22, 1'b0, 1'b0));
    add(sn(1'b1, 8'h00, 8'd0, 8'hEE), e_exec(8'd20, 8'h23, 1'b0, 5'd9, 4'd3, 1'b1, 1'b0, 1'b0));
    add(sn(1'b1, 8'h00, 8'd0, 8'hEE), e_exec(8'd21, 8'h23, 1'b0, 5'd10, 4'd4, 1'b0, 1'b0, 1'b1));
    last_opc = 8'h23;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL cond cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] cond cycle %0d ok upc=%0d z=%0b pcinc=%0b eof=%0b", n, oUpc, iFlagZ, oPcInc, oEof);
      n++;
    end
  endtask

  task automatic test_cb();
    sb_t e;
    int  n = 0;
    rom[30] = uop(4'd1, JCB, 4'd0);
    rom[16] = uop(4'd4, 5'd9, 4'd5);
    rom[40] = uop(4'd2, JCB, 4'd6);
    add(sn(1'b0, 8'hCB, 8'd30, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd30, 8'hCB, 1'b0, JCB, 4'd0, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h7C, 8'd99, 8'd16), e_idle(8'd0, 8'hCB, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd16, 8'h7C, 1'b1, 5'd9, 4'd5, 1'b0, 1'b1, 1'b1));
    // jcb carrying an ending flow code: end wins, back to regular dispatch
    add(sn(1'b0, 8'hCB, 8'd40, 8'hEE), e_idle(8'd0, 8'h7C, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd40, 8'hCB, 1'b0, JCB, 4'd6, 1'b0, 1'b0, 1'b1));
    last_opc = 8'hCB;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL cb cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] cb cycle %0d ok upc=%0d opc=%h cb=%0b fu=%0b eof=%0b", n, oUpc, oOpcode, oCbMode, oFlagUpdate, oEof);
      n++;
    end
  endtask

  task automatic test_stall();
    sb_t e;
    int  n = 0;
    rom[50] = uop(4'd1, 5'd11, 4'd1);
    rom[51] = uop(4'd1, 5'd12, 4'd2);
    rom[52] = uop(4'd3, 5'd13, 4'd3);
    add(sn(1'b0, 8'h55, 8'd50, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd50, 8'h55, 1'b0, 5'd11, 4'd1, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      add(st(1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 8'hEE), e_idle(8'd51, 8'h55, 1'b0, 1'b1));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd51, 8'h55, 1'b0, 5'd12, 4'd2, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd52, 8'h55, 1'b0, 5'd13, 4'd3, 1'b1, 1'b0, 1'b1));
    last_opc = 8'h55;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL stall cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] stall cycle %0d ok upc=%0d stall=%0b valid=%0b pcinc=%0b", n, oUpc, iStall, oUopValid, oPcInc);
      n++;
    end
  endtask

  task automatic test_back_to_back();
    sb_t        e;
    int         n = 0;
    logic [3:0] code;
    logic [4:0] op;
    logic [3:0] operand;
    logic [7:0] mop;
    logic [7:0] idx;
    logic       pi, fu;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: begin code = 4'd2; pi = 1'b0; fu = 1'b0; end
        1: begin code = 4'd3; pi = 1'b1; fu = 1'b0; end
        2: begin code = 4'd4; pi = 1'b0; fu = 1'b1; end
        default: begin code = 4'd5; pi = 1'b1; fu = 1'b1; end
      endcase
      op      = 5'($urandom_range(0, 19));
      operand = 4'($urandom);
      mop     = 8'($urandom);
      idx     = 8'(60 + i);
      rom[idx] = uop(code, op, operand);
      add(sn(1'b0, mop, idx, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
      add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(idx, mop, 1'b0, op, operand, pi, fu, 1'b1));
      last_opc = mop;
    end
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL b2b cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] b2b cycle %0d ok upc=%0d opc=%h pcinc=%0b fu=%0b eof=%0b", n, oUpc, oOpcode, oPcInc, oFlagUpdate, oEof);
      n++;
    end
  endtask

  task automatic test_wrap();
    sb_t e;
    int  n = 0;
    rom[254] = uop(4'd0, 5'd14, 4'd7);
    rom[255] = uop(4'd0, 5'd15, 4'd8);
    rom[0]   = uop(4'd2, 5'd16, 4'd9);
    add(sn(1'b0, 8'hAA, 8'd254, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd254, 8'hAA, 1'b0, 5'd14, 4'd7, 1'b0, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd255, 8'hAA, 1'b0, 5'd15, 4'd8, 1'b0, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd0, 8'hAA, 1'b0, 5'd16, 4'd9, 1'b0, 1'b0, 1'b1));
    last_opc = 8'hAA;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL wrap cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] wrap cycle %0d ok upc=%0d eof=%0b err=%0b", n, oUpc, oEof, oUopError);
      n++;
    end
  endtask

  task automatic test_reset_midflow();
    sb_t e;
    int  n = 0;
    rom[44] = uop(4'd1, JCB, 4'd0);
    rom[45] = uop(4'd0, 5'd1, 4'd1);
    rom[46] = uop(4'd0, 5'd2, 4'd2);
    rom[47] = uop(4'd2, 5'd3, 4'd3);
    add(sn(1'b0, 8'hCB, 8'd44, 8'hEE), e_idle(8'd0, last_opc, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd44, 8'hCB, 1'b0, JCB, 4'd0, 1'b1, 1'b0, 1'b0));
    add(sn(1'b0, 8'h11, 8'd0, 8'd45), e_idle(8'd0, 8'hCB, 1'b0, 1'b0));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd45, 8'h11, 1'b1, 5'd1, 4'd1, 1'b0, 1'b0, 1'b0));
    // reset lands mid CB flow: everything cleared without waiting for a clock
    add(st(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'hEE), e_zero());
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_zero());
    add(sn(1'b0, 8'h12, 8'd0, 8'hEE), e_idle(8'd0, 8'h00, 1'b0, 1'b1));
    add(sn(1'b0, 8'h00, 8'd0, 8'hEE), e_exec(8'd0, 8'h12, 1'b0, 5'd16, 4'd9, 1'b0, 1'b0, 1'b1));
    last_opc = 8'h12;
    while (stim_q.size() > 0) begin
      run_cycle(stim_q.pop_front());
      e = sb_q.pop_front();
      tests_run++;
      if ((obs & e.mask) !== (e.exp & e.mask)) begin
        tests_failed++;
        $display("FAIL rst_mid cycle %0d: got %h required %h (mask %h)", n, obs, e.exp, e.mask);
      end else
        $display("[TB] rst_mid cycle %0d ok upc=%0d opc=%h cb=%0b valid=%0b", n, oUpc, oOpcode, oCbMode, oUopValid);
      n++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_opc     = 8'h00;
    iReset       = 1'b0;
    iStall       = 1'b0;
    iFlagZ       = 1'b0;
    iMop         = 8'h00;
    iFlowIdx     = 8'h00;
    iCbFlowIdx   = 8'hEE;
    for (int a = 0; a < 256; a++) rom[a] = uop(4'd2, 5'd0, 4'd0);

    test_reset();
    test_flow_sequence();
    test_conditional();
    test_cb();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_midflow();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
